// File: rtl/offset_byte_serializer_if.sv
// Byte-stream bundle for offset_byte_serializer: raw sample input and offset byte output.
// The slave modport is the serializer itself; master is whatever drives it.
interface offset_byte_serializer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_idx;
    logic       out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/offset_byte_serializer.sv
// Buffers raw bytes in a 2-deep FIFO and emits each as four bytes, the head plus a
// per-index offset, with a running XOR checksum and a count of completed samples.
module offset_byte_serializer #(
    parameter int P  = 23,
    parameter int PX = 42
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    offset_byte_serializer_if.slave      bus,
    output logic [7:0]                   chk,
    output logic [15:0]                  sample_cnt
);
    localparam int          DATA_W = 8;
    localparam int          Q      = P + 13;
    localparam logic [7:0]  OFF0   = 8'(PX);
    localparam logic [7:0]  OFF1   = 8'(P + PX);
    localparam logic [7:0]  OFF2   = 8'(P);
    localparam logic [7:0]  OFF3   = 8'(Q ^ (Q - 37));

    function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    function automatic logic [DATA_W-1:0] offset_of(input logic [1:0] i);
        case (i)
            2'd0:    return OFF0;
            2'd1:    return OFF1;
            2'd2:    return OFF2;
            default: return OFF3;
        endcase
    endfunction

    logic [DATA_W-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic [1:0]        idx;
    // Low through reset and until the first edge after release, so in_ready stays low then.
    logic              alive;

    logic              push;
    logic              accept;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign head          = mem[rd_ptr];
    assign bus.in_ready  = alive && (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_idx   = idx;
    assign bus.out_last  = bus.out_valid && (idx == 2'd3);
    assign bus.out_data  = bus.out_valid ? add_mod(head, offset_of(idx)) : '0;

    assign push   = bus.in_valid && bus.in_ready;
    assign accept = bus.out_valid && bus.out_ready;
    assign pop    = accept && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive      <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            idx        <= 2'd0;
            chk        <= 8'd0;
            sample_cnt <= 16'd0;
        end else begin
            alive <= 1'b1;
            if (clear) begin
                rd_ptr     <= 1'b0;
                wr_ptr     <= 1'b0;
                count      <= 2'd0;
                idx        <= 2'd0;
                chk        <= 8'd0;
                sample_cnt <= 16'd0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop) begin
                    rd_ptr     <= ~rd_ptr;
                    sample_cnt <= sample_cnt + 16'd1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
                if (accept) begin
                    idx <= idx + 2'd1;
                    chk <= chk ^ bus.out_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_offset_byte_serializer.sv
// Randomised and directed bench for offset_byte_serializer against a queue-based model.
module tb_offset_byte_serializer;
    localparam int P  = 23;
    localparam int PX = 42;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [7:0]  chk;
    logic [15:0] sample_cnt;

    offset_byte_serializer_if bus();

    offset_byte_serializer #(.P(P), .PX(PX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bus        (bus),
        .chk        (chk),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: samples waiting, byte position in head sample, checksum, count.
    logic [7:0]  off [4];
    logic [7:0]  q [$];
    int          m_idx;
    logic [7:0]  m_chk;
    logic [15:0] m_cnt;
    bit          m_alive;
    bit          last_push;
    bit          last_acc;

    function automatic logic [7:0] exp_byte();
        if (q.size() == 0) return 8'h00;
        return 8'((int'(q[0]) + int'(off[m_idx])) % 256);
    endfunction

    task automatic model_reset();
        q.delete();
        m_idx = 0;
        m_chk = 8'h00;
        m_cnt = 16'h0000;
    endtask

    task automatic tick();
        bit push;
        bit acc;
        logic [7:0] din;
        push = bus.in_valid && m_alive && (q.size() < 2);
        acc  = (q.size() != 0) && bus.out_ready;
        din  = bus.in_data;
        @(posedge clk);
        last_push = 0;
        last_acc  = 0;
        if (clear) begin
            model_reset();
        end else begin
            if (acc) begin
                m_chk = m_chk ^ exp_byte();
                last_acc = 1;
                if (m_idx == 3) begin
                    void'(q.pop_front());
                    m_idx = 0;
                    m_cnt = m_cnt + 16'd1;
                end else begin
                    m_idx++;
                end
            end
            if (push) begin
                q.push_back(din);
                last_push = 1;
            end
        end
        m_alive = 1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_checks++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
        n_checks++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        n_checks++; if (chk !== 8'h00 || sample_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_counters: got chk=%h cnt=%h want 0", chk, sample_cnt); end
        @(posedge clk); #3;
        rst_n = 1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b want 0", bus.in_ready); end
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge: got %b want 1", bus.in_ready); end
    endtask

    task automatic run_sample(input logic [7:0] d, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input string name);
        logic [7:0] want [4];
        want[0] = b0; want[1] = b1; want[2] = b2; want[3] = b3;
        bus.in_valid = 1; bus.in_data = d; bus.out_ready = 1;
        tick();
        bus.in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== want[i] || bus.out_idx !== 2'(i) || bus.out_last !== (i == 3)) begin
                n_err++;
                $display("FAIL %s_byte%0d: got v=%b d=%h idx=%0d last=%b want v=1 d=%h idx=%0d last=%0b",
                         name, i, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, want[i], i, (i == 3));
            end
            tick();
        end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL %s_idle: got out_valid=%b want 0", name, bus.out_valid); end
    endtask

    task automatic test_single();
        run_sample(8'h10, 8'h3A, 8'h51, 8'h27, 8'hEB, "single");
        n_checks++; if (chk !== 8'hA7) begin n_err++; $display("FAIL single_chk: got %h want a7", chk); end
        n_checks++; if (sample_cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt: got %0d want 1", sample_cnt); end
    endtask

    task automatic test_wrap();
        run_sample(8'hF0, 8'h1A, 8'h31, 8'h07, 8'hCB, "wrap");
        n_checks++; if (chk !== m_chk || sample_cnt !== m_cnt) begin n_err++; $display("FAIL wrap_counters: got chk=%h cnt=%0d want chk=%h cnt=%0d", chk, sample_cnt, m_chk, m_cnt); end
    endtask

    task automatic test_backpressure();
        int accepted;
        int acc_at_push;
        bit third_in;
        bus.out_ready = 0;
        bus.in_valid = 1; bus.in_data = 8'h01; tick();
        bus.in_data = 8'h02; tick();
        bus.in_data = 8'h03;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_data !== 8'h2B || bus.out_idx !== 2'd0) begin
                n_err++;
                $display("FAIL full_hold%0d: got rdy=%b d=%h idx=%0d want rdy=0 d=2b idx=0", i, bus.in_ready, bus.out_data, bus.out_idx);
            end
            tick();
        end
        bus.out_ready = 1;
        accepted = 0; acc_at_push = -1; third_in = 0;
        for (int c = 0; c < 20; c++) begin
            n_checks++;
            if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() < 2) ||
                (bus.out_valid && bus.out_data !== exp_byte())) begin
                n_err++;
                $display("FAIL drain_c%0d: got v=%b rdy=%b d=%h want v=%0b rdy=%0b d=%h", c, bus.out_valid, bus.in_ready, bus.out_data, (q.size() != 0), (q.size() < 2), exp_byte());
            end
            tick();
            if (last_push && !third_in) begin acc_at_push = accepted; third_in = 1; bus.in_valid = 0; end
            if (last_acc) accepted++;
        end
        n_checks++; if (acc_at_push !== 4) begin n_err++; $display("FAIL third_accept_time: got %0d bytes before push want 4", acc_at_push); end
        n_checks++; if (accepted !== 12) begin n_err++; $display("FAIL drain_bytes: got %0d want 12", accepted); end
    endtask

    task automatic test_stall();
        logic [7:0] d;
        d = 8'($urandom);
        bus.in_valid = 1; bus.in_data = d; bus.out_ready = 1;
        tick();
        bus.in_valid = 0;
        tick(); tick();
        bus.out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.out_idx !== 2'd2 || bus.out_data !== 8'(d + 8'(P)) || bus.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall%0d: got idx=%0d d=%h want idx=2 d=%h", i, bus.out_idx, bus.out_data, 8'(d + 8'(P)));
            end
            tick();
        end
        bus.out_ready = 1;
        tick();
        n_checks++;
        if (bus.out_idx !== 2'd3 || bus.out_data !== exp_byte() || bus.out_last !== 1'b1) begin
            n_err++;
            $display("FAIL stall_resume: got idx=%0d d=%h last=%b want idx=3 d=%h last=1", bus.out_idx, bus.out_data, bus.out_last, exp_byte());
        end
        tick();
    endtask

    task automatic test_clear();
        bus.in_valid = 1; bus.in_data = 8'($urandom); bus.out_ready = 1;
        tick();
        bus.in_valid = 0;
        tick();
        n_checks++; if (bus.out_idx !== 2'd1) begin n_err++; $display("FAIL clear_setup_idx: got %0d want 1", bus.out_idx); end
        clear = 1; bus.in_valid = 1; bus.in_data = 8'h5A;
        tick();
        clear = 0; bus.in_valid = 0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || chk !== 8'h00 || sample_cnt !== 16'h0000 || bus.out_idx !== 2'd0) begin
            n_err++;
            $display("FAIL clear_flush: got v=%b chk=%h cnt=%0d idx=%0d want 0", bus.out_valid, chk, sample_cnt, bus.out_idx);
        end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL clear_push_lost: got out_valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            clear         = ($urandom_range(0, 59) == 0);
            tick();
            clear = 0;
            n_checks++;
            if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() < 2) ||
                bus.out_idx !== 2'(m_idx) || bus.out_last !== (q.size() != 0 && m_idx == 3) ||
                bus.out_data !== exp_byte() || chk !== m_chk || sample_cnt !== m_cnt) begin
                n_err++;
                if (bad < 10)
                    $display("FAIL random_c%0d: got v=%b rdy=%b d=%h idx=%0d chk=%h cnt=%0d want v=%0b rdy=%0b d=%h idx=%0d chk=%h cnt=%0d",
                             c, bus.out_valid, bus.in_ready, bus.out_data, bus.out_idx, chk, sample_cnt,
                             (q.size() != 0), (q.size() < 2), exp_byte(), m_idx, m_chk, m_cnt);
                bad++;
            end
        end
        bus.in_valid = 0; bus.out_ready = 1;
        for (int c = 0; c < 10; c++) tick();
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1; bus.in_data = 8'($urandom); bus.out_ready = 1;
        tick();
        bus.in_valid = 0;
        tick(); tick();
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.in_ready !== 1'b0 || bus.out_idx !== 2'd0 ||
            chk !== 8'h00 || sample_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL async_reset: got v=%b d=%h rdy=%b idx=%0d chk=%h cnt=%0d want all 0", bus.out_valid, bus.out_data, bus.in_ready, bus.out_idx, chk, sample_cnt);
        end
        model_reset();
        m_alive = 0;
        #2 rst_n = 1;
        #1;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_partial: got out_valid=%b want 0", bus.out_valid); end
        run_sample(8'h00, 8'h2A, 8'h41, 8'h17, 8'hDB, "post_reset");
    endtask

    initial begin
        clk = 0; rst_n = 0; clear = 0;
        bus.in_valid = 0; bus.in_data = 8'h00; bus.out_ready = 0;
        off[0] = 8'(PX);
        off[1] = 8'(P + PX);
        off[2] = 8'(P);
        off[3] = 8'((P + 13) ^ (P + 13 - 37));
        model_reset();
        m_alive = 0;
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_stall();
        test_clear();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/offset_byte_serializer.md
OFFSET_BYTE_SERIALIZER -- requirements
Module: offset_byte_serializer

Interface
REQ-001 SHALL have parameter P, default 23: base offset; output byte 2 offset = P.
REQ-002 SHALL have parameter PX, default 42: output byte 0 offset = PX; output byte 1 offset = P+PX.
REQ-003 SHALL derive byte-3 offset internally as Q ^ (Q-37), where Q = P+13, truncated to 8 bits (219 = 8'hDB at defaults); this offset is not overridable.
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 clear  input  1  synchronous flush, active-high.
REQ-007 in_valid  input  1  upstream sample valid.
REQ-008 in_ready  output  1  block can accept a sample.
REQ-009 in_data  input  8  raw sample.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts byte.
REQ-012 out_data  output  8  offset result byte.
REQ-013 out_idx  output  2  index (0..3) of current byte within sample.
REQ-014 out_last  output  1  high when out_idx==3 and out_valid.
REQ-015 chk  output  8  running XOR of all accepted output bytes.
REQ-016 sample_cnt  output  16  number of fully emitted samples.

Function
REQ-017 SHALL buffer raw samples in a 2-entry FIFO; push = in_valid && in_ready; in_ready = (count < 2), registered-state only, no dependence on out_ready.
REQ-018 SHALL drive out_valid = (count != 0); out_data = (head + OFFSET[out_idx]) mod 256, OFFSET = {PX, P+PX, P, byte-3 offset}; outputs depend on registers only.
REQ-019 SHALL emit, per sample, bytes in order idx 0,1,2,3; idx advances only on out_valid && out_ready.
REQ-020 SHALL pop the FIFO head and wrap idx 3->0 when the idx-3 byte is accepted.
REQ-021 Latency: sample pushed at edge N into empty FIFO SHALL appear as idx-0 byte with out_valid high after edge N (one cycle); back-to-back samples SHALL stream with no bubble.
REQ-022 Simultaneous push and pop at count 1 SHALL leave count at 1; at count 2 no push occurs.
REQ-023 out_valid high with out_ready low SHALL hold out_data, out_idx, out_last stable.
REQ-024 chk SHALL update chk <= chk ^ out_data on every accepted byte.
REQ-025 sample_cnt SHALL increment on every pop, wrapping 16'hFFFF -> 0.
REQ-026 clear SHALL, on the next edge, empty the FIFO, zero idx, chk, sample_cnt; clear overrides same-cycle push and pop (the pushed sample is discarded).
REQ-027 Addition SHALL be 8-bit modular; carry discarded.

Reset
REQ-028 rst_n low SHALL immediately force: FIFO empty, idx=0, out_valid=0, out_last=0, in_ready=0, chk=0, sample_cnt=0, out_data=0.
REQ-029 in_ready SHALL rise on the first clock edge after rst_n deasserts; reset mid-sample SHALL discard partial sample with no further bytes emitted.

Verification
REQ-030 Single sample: in_data=8'h10, out_ready=1 -> bytes 3A,51,27,EB on four consecutive cycles, out_last on EB, chk=8'hA7, sample_cnt=1.
REQ-031 Wrap: in_data=8'hF0 -> bytes 1A,31,07,CB.
REQ-032 Backpressure/full: out_ready=0, offer 3 samples (01,02,03) -> in_ready low after 2 pushes, out_data held at 2B; release out_ready -> 8 bytes for 01 then 02, third sample accepted only after 01's last byte.
REQ-033 Stall mid-sample: drop out_ready at idx 2 for 5 cycles -> out_idx=2, out_data unchanged; resumes with idx 3.
REQ-034 clear during idx 1 with concurrent push -> next cycle out_valid=0, chk=0, sample_cnt=0, pushed sample lost.
REQ-035 rst_n pulsed low mid-sample (asynchronous, between edges) -> outputs zero immediately; after release, new sample 8'h00 emits 2A,41,17,DB.
